// File: rtl/uart_pkg.sv
// +----------------------------------------------------------------------+
// | uart_pkg : shared FSM encoding, parity constants and timer helpers    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  localparam int TIMER_W = 6;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Reload value for a down-counter that must expire after n cycles; n=0 acts as n=1.
  function automatic logic [TIMER_W-1:0] bit_len_m1(input logic [TIMER_W-1:0] n);
    logic [TIMER_W-1:0] r;
    r = '0;
    if (n != '0) r = n - 1'b1;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tx_bit_timer.sv
// +----------------------------------------------------------------------+
// | tx_bit_timer : per-bit down-counter, bit_done flags the last cycle    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tx_bit_timer
  import uart_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] N,
  output logic               bit_done
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = bit_len_m1(N);
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign bit_done = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// +----------------------------------------------------------------------+
// | uart_tx : serialiser, start / LSB-first data / opt. parity / stop     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            prescale,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [5:0]            prescale_q, prescale_d;
  logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
  logic                  tx_out_q, tx_out_d;
  logic                  busy_q, busy_d;

  logic                  timer_load;
  logic [5:0]            timer_n;
  logic                  bit_done;
  logic                  parity_bit;
  logic [IDX_W-1:0]      bit_idx_inc;

  assign parity_bit  = (^data_q) ^ (par_typ_q == PAR_ODD);
  assign bit_idx_inc = bit_idx_q + 1'b1;
  // The first bit is timed from the live prescale because capture happens on the same edge.
  assign timer_n     = (state_q == IDLE) ? prescale : prescale_q;

  tx_bit_timer u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .N        (timer_n),
    .bit_done (bit_done)
  );

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    prescale_d = prescale_q;
    bit_idx_d  = bit_idx_q;
    tx_out_d   = tx_out_q;
    busy_d     = busy_q;
    timer_load = 1'b0;

    case (state_q)
      IDLE: begin
        tx_out_d = 1'b1;
        busy_d   = 1'b0;
        if (Data_Valid) begin
          data_d     = P_DATA;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          prescale_d = prescale;
          bit_idx_d  = '0;
          state_d    = START;
          tx_out_d   = 1'b0;
          busy_d     = 1'b1;
          timer_load = 1'b1;
        end
      end
      START: begin
        if (bit_done) begin
          state_d    = DATA;
          tx_out_d   = data_q[0];
          timer_load = 1'b1;
        end
      end
      DATA: begin
        if (bit_done) begin
          timer_load = 1'b1;
          if (bit_idx_q == LAST_IDX) begin
            bit_idx_d = '0;
            if (par_en_q) begin
              state_d  = PARITY;
              tx_out_d = parity_bit;
            end else begin
              state_d  = STOP;
              tx_out_d = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_inc;
            tx_out_d  = data_q[bit_idx_inc];
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_d    = STOP;
          tx_out_d   = 1'b1;
          timer_load = 1'b1;
        end
      end
      STOP: begin
        if (bit_done) begin
          state_d  = IDLE;
          tx_out_d = 1'b1;
          busy_d   = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        tx_out_d = 1'b1;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      prescale_q <= '0;
      bit_idx_q  <= '0;
      tx_out_q   <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      prescale_q <= prescale_d;
      bit_idx_q  <= bit_idx_d;
      tx_out_q   <= tx_out_d;
      busy_q     <= busy_d;
    end
  end

  assign TX_OUT = tx_out_q;
  assign busy   = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// +----------------------------------------------------------------------+
// | tb_uart_tx : directed frames, scoreboard queue checked by a monitor   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] P_DATA = 8'h00;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [5:0] prescale = 6'd0;
  logic       TX_OUT;
  logic       busy;

  uart_tx #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .prescale   (prescale),
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] bits;
    int          len;
    int          n;
  } frame_t;

  frame_t exp_q[$];
  int     checks = 0;
  int     errors = 0;
  int     frames_pushed = 0;
  int     frames_done = 0;
  bit     mon_en = 1'b1;
  logic   busy_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic frame_t make_frame(input logic [7:0] d, input logic pe,
                                        input logic pbit, input int n);
    frame_t f;
    f.bits    = '1;
    f.bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) f.bits[i+1] = d[i];
    if (pe) begin
      f.bits[9] = pbit;
      f.len     = 11;
    end else begin
      f.len     = 10;
    end
    f.n = n;
    return f;
  endfunction

  task automatic pulse(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps);
    @(negedge clk);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    prescale   = ps;
    Data_Valid = 1'b1;
    @(negedge clk);
    Data_Valid = 1'b0;
  endtask

  // exp_par and exp_n are hand-derived for each vector.
  task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps,
                      input logic exp_par, input int exp_n);
    exp_q.push_back(make_frame(d, pe, exp_par, exp_n));
    frames_pushed++;
    pulse(d, pe, pt, ps);
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (frames_done < frames_pushed && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check(name, frames_done, frames_pushed);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_frame();
    frame_t f;
    int     bc;
    int     t;
    logic   ok;
    logic   bad_val;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_frame: busy rose with no request pending, required idle");
      t = 0;
      while (busy === 1'b1 && t < 2000) begin
        @(negedge clk);
        t++;
      end
    end else begin
      f  = exp_q.pop_front();
      bc = 0;
      for (int i = 0; i < f.len; i++) begin
        ok      = 1'b1;
        bad_val = f.bits[i];
        for (int k = 0; k < f.n; k++) begin
          if (i != 0 || k != 0) @(negedge clk);
          if (TX_OUT !== f.bits[i]) begin
            ok      = 1'b0;
            bad_val = TX_OUT;
          end
          if (busy === 1'b1) bc++;
        end
        check($sformatf("frame%0d_bit%0d", frames_done, i), {31'd0, bad_val}, {31'd0, f.bits[i]});
      end
      @(negedge clk);
      check($sformatf("frame%0d_busy_cycles", frames_done), bc, f.len * f.n);
      check($sformatf("frame%0d_idle_after", frames_done), {30'd0, busy, TX_OUT}, 32'd1);
      frames_done++;
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (mon_en && busy === 1'b1 && busy_prev !== 1'b1) run_frame();
      busy_prev = busy;
    end
  end

  initial begin : stimulus
    logic ok;
    repeat (3) @(negedge clk);
    check("reset_tx_out", {31'd0, TX_OUT}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // 0xA5 has four ones: even parity bit 0.
    send(8'hA5, 1'b1, 1'b0, 6'd8, 1'b0, 8);
    wait_done("done_a5");
    send(8'hFF, 1'b0, 1'b0, 6'd4, 1'b0, 4);
    wait_done("done_ff");
    send(8'h01, 1'b1, 1'b1, 6'd5, 1'b0, 5);
    wait_done("done_01_odd");
    send(8'h01, 1'b1, 1'b0, 6'd5, 1'b1, 5);
    wait_done("done_01_even");

    // Second request mid-frame must be dropped; inputs left changed until frame end.
    send(8'h5A, 1'b0, 1'b0, 6'd4, 1'b0, 4);
    repeat (12) @(negedge clk);
    pulse(8'h3C, 1'b1, 1'b1, 6'd2);
    wait_done("done_5a");
    repeat (20) @(negedge clk);
    check("dropped_3c_idle", {30'd0, busy, TX_OUT}, 32'd1);

    // 0x6B has five ones: even parity bit 1; prescale 0 means 1 cycle per bit.
    send(8'h6B, 1'b1, 1'b0, 6'd0, 1'b1, 1);
    wait_done("done_6b");
    send(8'hC3, 1'b0, 1'b0, 6'd1, 1'b0, 1);
    wait_done("done_c3_p1");

    // Abort during data bit 3 (cycles 64..79 of a prescale-16 frame).
    mon_en = 1'b0;
    pulse(8'hC3, 1'b1, 1'b0, 6'd16);
    repeat (70) @(negedge clk);
    check("pre_reset_bit3", {31'd0, TX_OUT}, 32'd0);
    rst        = 1'b0;
    Data_Valid = 1'b1;
    P_DATA     = 8'h3C;
    @(negedge clk);
    check("abort_tx_high", {31'd0, TX_OUT}, 32'd1);
    check("abort_busy_low", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst        = 1'b1;
    Data_Valid = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (TX_OUT !== 1'b1 || busy !== 1'b0) ok = 1'b0;
    end
    check("no_residual_after_reset", {31'd0, ok}, 32'd1);
    mon_en = 1'b1;

    // 0x81 has two ones: even parity bit 0.
    send(8'h81, 1'b1, 1'b0, 6'd3, 1'b0, 3);
    wait_done("done_81");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
